// File: rtl/count_source_if.sv
// Handshake bundle between the count source controller and its board I/O.
// Inputs: pulsa, selector (raw). Outputs: cnt_en, mode, tick_10hz.
interface count_source_if;
  logic pulsa;
  logic selector;
  logic cnt_en;
  logic mode;
  logic tick_10hz;

  modport master (
    output pulsa,
    output selector,
    input  cnt_en,
    input  mode,
    input  tick_10hz
  );

  modport slave (
    input  pulsa,
    input  selector,
    output cnt_en,
    output mode,
    output tick_10hz
  );
endinterface

// File: rtl/count_source_ctrl.sv
// Count-enable strobe for the BCD counter: auto 10 Hz tick or debounced button.
// Ports: clk, rst_n (async low), bus.slave {pulsa, selector -> cnt_en, mode, tick_10hz}.
module count_source_ctrl #(
  parameter int DIV_10HZ   = 5_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input logic           clk,
  input logic           rst_n,
  count_source_if.slave bus
);

  localparam int PW = $clog2(DIV_10HZ);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    AUTO,
    MANUAL,
    SWITCH
  } state_t;

  logic          p_s1_q, p_s1_d;
  logic          p_s2_q, p_s2_d;
  logic          s_s1_q, s_s1_d;
  logic          s_s2_q, s_s2_d;
  logic          p_deb_q, p_deb_d;
  logic          s_deb_q, s_deb_d;
  logic [DW-1:0] p_cnt_q, p_cnt_d;
  logic [DW-1:0] s_cnt_q, s_cnt_d;
  logic          p_prev_q, p_prev_d;
  logic [PW-1:0] pre_q, pre_d;
  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic          cnt_en_q, cnt_en_d;
  logic          tick_q, tick_d;
  logic          rise;
  logic          wrap;

  // Returns {level, counter}. The level flips on the (DEB_CYCLES+1)th
  // consecutive disagreeing cycle; any agreeing cycle clears the counter.
  function automatic logic [DW:0] deb_next(
    input logic          s,
    input logic          lvl,
    input logic [DW-1:0] cnt
  );
    logic [DW:0] r;
    r = {lvl, {DW{1'b0}}};
    if (s != lvl) begin
      if (cnt == DW'(DEB_CYCLES)) r = {s, {DW{1'b0}}};
      else                        r = {lvl, cnt + DW'(1)};
    end
    return r;
  endfunction

  always_comb begin
    p_s1_d = bus.pulsa;
    p_s2_d = p_s1_q;
    s_s1_d = bus.selector;
    s_s2_d = s_s1_q;
    {p_deb_d, p_cnt_d} = deb_next(p_s2_q, p_deb_q, p_cnt_q);
    {s_deb_d, s_cnt_d} = deb_next(s_s2_q, s_deb_q, s_cnt_q);
    // Edge history tracks in every state, so a held button never
    // looks like a fresh press after a mode change.
    p_prev_d = p_deb_q;
    rise     = p_deb_q & ~p_prev_q;
    wrap     = (pre_q == PW'(DIV_10HZ - 1));
    pre_d    = wrap ? '0 : pre_q + PW'(1);
    tick_d   = wrap;
    cnt_en_d = 1'b0;
    mode_d   = mode_q;
    state_d  = state_q;
    if (state_q == SWITCH) begin
      pre_d   = '0;
      tick_d  = 1'b0;
      state_d = mode_q ? MANUAL : AUTO;
    end else if (s_deb_q != mode_q) begin
      // Mode change beats any coincident tick or press.
      state_d = SWITCH;
      mode_d  = s_deb_q;
      pre_d   = '0;
      tick_d  = 1'b0;
    end else begin
      unique case (1'b1)
        state_q == AUTO:   cnt_en_d = wrap;
        state_q == MANUAL: cnt_en_d = rise;
        default:           cnt_en_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1_q   <= 1'b0;
      p_s2_q   <= 1'b0;
      s_s1_q   <= 1'b0;
      s_s2_q   <= 1'b0;
      p_deb_q  <= 1'b0;
      s_deb_q  <= 1'b0;
      p_cnt_q  <= '0;
      s_cnt_q  <= '0;
      p_prev_q <= 1'b0;
      pre_q    <= '0;
      state_q  <= AUTO;
      mode_q   <= 1'b0;
      cnt_en_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      p_s1_q   <= p_s1_d;
      p_s2_q   <= p_s2_d;
      s_s1_q   <= s_s1_d;
      s_s2_q   <= s_s2_d;
      p_deb_q  <= p_deb_d;
      s_deb_q  <= s_deb_d;
      p_cnt_q  <= p_cnt_d;
      s_cnt_q  <= s_cnt_d;
      p_prev_q <= p_prev_d;
      pre_q    <= pre_d;
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_en_q <= cnt_en_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.cnt_en    = cnt_en_q;
  assign bus.mode      = mode_q;
  assign bus.tick_10hz = tick_q;

endmodule

// File: tb/tb_count_source_ctrl.sv
// Directed and random checks of count_source_ctrl against a history model.
// DIV_10HZ=10, DEB_CYCLES=4.
module tb_count_source_ctrl;

  localparam int DIV = 10;
  localparam int DEB = 4;
  localparam int HN  = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  count_source_if bus();

  count_source_ctrl #(
    .DIV_10HZ  (DIV),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // raw input seen at edge k, and debounced level after edge k
  bit hp [0:HN-1];
  bit hs [0:HN-1];
  bit dp [0:HN-1];
  bit ds [0:HN-1];

  int n;
  int anchor;
  bit mode_m;
  bit sw;
  bit ec;
  bit et;
  bit prev_cnt;
  int pulses;
  int pulse_edge;

  function automatic bit rawv(bit w, int i);
    if (i < 0) return 1'b0;
    return w ? hs[i] : hp[i];
  endfunction

  function automatic bit debv(bit w, int i);
    if (i < 0) return 1'b0;
    return w ? ds[i] : dp[i];
  endfunction

  function automatic bit stable(bit w, int hi, bit v);
    for (int j = hi - DEB; j <= hi; j++)
      if (rawv(w, j) != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    n = 0;
    anchor = 0;
    mode_m = 1'b0;
    sw = 1'b0;
    ec = 1'b0;
    et = 1'b0;
    prev_cnt = 1'b0;
  endtask

  task automatic model_edge(input bit p, input bit s);
    bit dsel;
    bit rs;
    bit old;
    bit v;
    hp[n] = p;
    hs[n] = s;
    dsel = debv(1'b1, n - 1);
    rs = debv(1'b0, n - 1) & ~debv(1'b0, n - 2);
    ec = 1'b0;
    et = 1'b0;
    if (dsel != mode_m) begin
      mode_m = dsel;
      anchor = n + 2;
      sw = 1'b1;
    end else if (sw) begin
      sw = 1'b0;
    end else begin
      et = ((n - anchor) % DIV) == DIV - 1;
      ec = mode_m ? rs : et;
    end
    for (int w = 0; w < 2; w++) begin
      old = debv(w[0], n - 1);
      v = rawv(w[0], n - 2);
      if (v != old && stable(w[0], n - 2, v)) old = v;
      if (w == 0) dp[n] = old;
      else        ds[n] = old;
    end
    n++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%b want=%b", tag, n - 1, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit p;
    bit s;
    p = bus.pulsa;
    s = bus.selector;
    @(posedge clk);
    model_edge(p, s);
    #1;
    chk("cnt_en", bus.cnt_en, ec);
    chk("mode", bus.mode, mode_m);
    chk("tick", bus.tick_10hz, et);
    chk("double", bus.cnt_en & prev_cnt, 1'b0);
    prev_cnt = bus.cnt_en;
    if (bus.cnt_en) begin
      pulses++;
      pulse_edge = n - 1;
    end
  endtask

  task automatic do_reset(input bit p, input bit s);
    rst_n = 1'b0;
    #1;
    chk("rst_cnt_en", bus.cnt_en, 1'b0);
    chk("rst_mode", bus.mode, 1'b0);
    chk("rst_tick", bus.tick_10hz, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.pulsa = p;
    bus.selector = s;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int k;
    int len;
    bus.pulsa = 1'b0;
    bus.selector = 1'b0;
    #2;
    do_reset(1'b0, 1'b0);

    pulses = 0;
    repeat (35) step();
    chk_int("t1_pulses", pulses, 3);
    chk_int("t1_last", pulse_edge, 29);

    do_reset(1'b0, 1'b1);
    repeat (7) step();
    chk("t2_mode_e6", bus.mode, 1'b0);
    step();
    chk("t2_mode_e7", bus.mode, 1'b1);
    while (n < 20) step();
    bus.pulsa = 1'b1;
    pulses = 0;
    repeat (20) step();
    bus.pulsa = 1'b0;
    repeat (15) step();
    chk_int("t2_pulses", pulses, 1);
    chk_int("t2_edge", pulse_edge, 27);

    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      bus.pulsa = (i % 4) < 2;
      step();
    end
    k = n;
    bus.pulsa = 1'b1;
    repeat (10) step();
    bus.pulsa = 1'b0;
    repeat (10) step();
    chk_int("t3_pulses", pulses, 1);
    chk_int("t3_edge", pulse_edge, k + 7);

    bus.selector = 1'b0;
    repeat (20) step();
    while (((n + 7 - anchor) % DIV) != DIV - 1) step();
    bus.selector = 1'b1;
    repeat (8) step();
    chk("t4_drop", bus.cnt_en, 1'b0);
    repeat (15) step();
    k = n;
    bus.selector = 1'b0;
    pulses = 0;
    repeat (19) step();
    chk_int("t4_pulses", pulses, 1);
    chk_int("t4_edge", pulse_edge, k + 18);

    bus.pulsa = 1'b1;
    repeat (10) step();
    bus.selector = 1'b1;
    repeat (7) step();
    pulses = 0;
    repeat (20) step();
    chk_int("t5_held", pulses, 0);
    bus.pulsa = 1'b0;
    repeat (10) step();
    chk_int("t5_release", pulses, 0);
    bus.pulsa = 1'b1;
    repeat (12) step();
    chk_int("t5_repress", pulses, 1);

    bus.pulsa = 1'b0;
    bus.selector = 1'b0;
    repeat (20) step();
    while (((n + 2 - anchor) % DIV) != DIV - 1) step();
    bus.pulsa = 1'b1;
    repeat (3) step();
    chk("t6_high", bus.cnt_en, 1'b1);
    do_reset(1'b0, 1'b1);
    pulses = 0;
    repeat (30) step();
    chk_int("t6_quiet", pulses, 0);
    bus.pulsa = 1'b1;
    repeat (12) step();
    chk_int("t6_fresh", pulses, 1);
    bus.pulsa = 1'b0;
    repeat (10) step();

    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 3) == 0)
          bus.selector = ~bus.selector;
        else
          bus.pulsa = ~bus.pulsa;
      end
      len = $urandom_range(1, 12);
      repeat (len) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
